spi_slv_regfile: RTL and testbench

- SPI slave endpoint that sits directly downstream of the SPI master pins (sck/cs_n/mosi/miso).
- Holds a byte-wide register file that an SPI master reads and writes with a command byte followed by auto-incrementing data bytes.
- Used as an on-chip peripheral model and loopback target for SPI master bring-up. Also exposes a local read/write port on the system side.

---
 rtl/spi_slv_regfile_if.sv | 28 ++
 rtl/spi_slv_regfile.sv | 152 +++++++++++++++
 tb/tb_spi_slv_regfile.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slv_regfile_if.sv
// Pin-side SPI signals plus the local register port and write-notification outputs
// of the SPI slave register file.
interface spi_slv_regfile_if #(
  parameter int ADDR_W = 4
);
  logic              sck_i;
  logic              cs_ni;
  logic              mosi_i;
  logic              miso_o;
  logic              miso_oe_o;
  logic              lcl_we_i;
  logic [ADDR_W-1:0] lcl_addr_i;
  logic [7:0]        lcl_data_i;
  logic [7:0]        lcl_rdata_o;
  logic              wr_stb_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [7:0]        wr_data_o;

  modport slave (
    input  sck_i, cs_ni, mosi_i, lcl_we_i, lcl_addr_i, lcl_data_i,
    output miso_o, miso_oe_o, lcl_rdata_o, wr_stb_o, wr_addr_o, wr_data_o
  );

  modport master (
    output sck_i, cs_ni, mosi_i, lcl_we_i, lcl_addr_i, lcl_data_i,
    input  miso_o, miso_oe_o, lcl_rdata_o, wr_stb_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/spi_slv_regfile.sv
// SPI mode-0 slave with a byte-wide register file: command byte (bit7 = read) then
// auto-incrementing data bytes; local write port and SPI write notification on the system side.
module spi_slv_regfile #(
  parameter int ADDR_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  spi_slv_regfile_if.slave bus
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;

  state_e            state_q, state_d;
  logic              sck_meta_q, sck_sync_q, sck_dly_q;
  logic              cs_meta_q, cs_sync_q;
  logic              mosi_meta_q, mosi_sync_q;
  logic [1:0]        flush_q;
  logic              armed_q;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        rx_sh_q, rx_sh_d;
  logic [7:0]        tx_sh_q, tx_sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_stb_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        regs [NUM_REGS];

  logic              sck_rise, sck_fall, byte_done, spi_we;
  logic [7:0]        rx_byte;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_dly_q   <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      flush_q     <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      sck_meta_q  <= bus.sck_i;
      sck_sync_q  <= sck_meta_q;
      sck_dly_q   <= sck_sync_q;
      cs_meta_q   <= bus.cs_ni;
      cs_sync_q   <= cs_meta_q;
      mosi_meta_q <= bus.mosi_i;
      mosi_sync_q <= mosi_meta_q;
      flush_q     <= {flush_q[0], 1'b1};
      // Only a genuinely observed deselect (not the reset value) may start a command.
      armed_q     <= armed_q | (flush_q[1] & cs_sync_q);
    end
  end

  assign sck_rise  = sck_sync_q & ~sck_dly_q & ~cs_sync_q;
  assign sck_fall  = ~sck_sync_q & sck_dly_q & ~cs_sync_q;
  assign rx_byte   = {rx_sh_q[6:0], mosi_sync_q};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign spi_we    = byte_done && (state_q == WDATA);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_sh_q   <= '0;
      tx_sh_q   <= '0;
      addr_q    <= '0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sh_q   <= rx_sh_d;
      tx_sh_q   <= tx_sh_d;
      addr_q    <= addr_d;
      wr_stb_q  <= spi_we;
      if (spi_we) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (cs_sync_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (armed_q) state_d = CMD;
        CMD:     if (byte_done) state_d = rx_byte[7] ? RDATA : WDATA;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    addr_d    = addr_q;
    if (cs_sync_q) begin
      bit_cnt_d = '0;
      tx_sh_d   = '0;
    end else begin
      if (sck_rise) begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        rx_sh_d   = rx_byte;
      end
      if (byte_done && state_q == CMD) addr_d = rx_byte[ADDR_W-1:0];
      if (spi_we) addr_d = addr_q + 1'b1;
      // The first fall of each read byte snapshots the register; later falls shift.
      if (sck_fall && state_q == RDATA) begin
        if (bit_cnt_q == 3'd0) begin
          tx_sh_d = regs[addr_q];
          addr_d  = addr_q + 1'b1;
        end else begin
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    bus.miso_o    = 1'b0;
    if (state_q == RDATA) bus.miso_o = tx_sh_q[7];
    bus.miso_oe_o = ~cs_sync_q;
  end

  // SPI write has priority over a local write to the same index.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    logic [7:0] reg_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        reg_q <= '0;
      end else if (spi_we && addr_q == ADDR_W'(gi)) begin
        reg_q <= rx_byte;
      end else if (bus.lcl_we_i && bus.lcl_addr_i == ADDR_W'(gi)) begin
        reg_q <= bus.lcl_data_i;
      end
    end
    assign regs[gi] = reg_q;
  end

  assign bus.lcl_rdata_o = regs[bus.lcl_addr_i];
  assign bus.wr_stb_o    = wr_stb_q;
  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;
endmodule

// File: tb/tb_spi_slv_regfile.sv
// Directed bench for spi_slv_regfile: bit-banged SPI mode-0 master at f_clk/8,
// write/read bursts, wrap, abort, local-write collision and mid-transfer reset.
module tb_spi_slv_regfile;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  logic [11:0] stb_log [$];
  logic [7:0]  rx;
  logic [7:0]  v;

  always #5 clk = ~clk;

  spi_slv_regfile_if #(.ADDR_W(4)) bus ();
  spi_slv_regfile #(.ADDR_W(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always @(negedge clk) if (bus.wr_stb_o === 1'b1) stb_log.push_back({bus.wr_addr_o, bus.wr_data_o});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic spi_bit(input logic b, output logic so);
    bus.mosi_i = b;
    repeat (4) @(negedge clk);
    so = bus.miso_o;
    bus.sck_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.sck_i = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
    logic so;
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_bit(tx[i], so);
      r[i] = so;
    end
  endtask

  // Last bit is hand-timed so a one-cycle local write lands on the SPI write edge.
  task automatic spi_byte_coll(input logic [7:0] tx, input logic [3:0] la, input logic [7:0] ld);
    logic [7:0] r;
    spi_bits(tx, 7, r);
    bus.mosi_i = tx[0];
    repeat (4) @(negedge clk);
    bus.sck_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.lcl_we_i = 1'b1;
    bus.lcl_addr_i = la;
    bus.lcl_data_i = ld;
    @(posedge clk);
    #1;
    bus.lcl_we_i = 1'b0;
    chk("coll_stb_aligned", bus.wr_stb_o, 1);
    repeat (2) @(negedge clk);
    bus.sck_i = 1'b0;
  endtask

  task automatic cs_begin();
    bus.cs_ni = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (4) @(negedge clk);
    bus.cs_ni = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic peek(input int idx, output logic [7:0] d);
    bus.lcl_addr_i = 4'(idx);
    #1;
    d = bus.lcl_rdata_o;
  endtask

  initial begin
    rst = 1'b1;
    bus.sck_i = 1'b0;
    bus.cs_ni = 1'b1;
    bus.mosi_i = 1'b0;
    bus.lcl_we_i = 1'b0;
    bus.lcl_addr_i = '0;
    bus.lcl_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_miso", bus.miso_o, 0);
    chk("rst_miso_oe", bus.miso_oe_o, 0);
    chk("rst_wr_stb", bus.wr_stb_o, 0);
    chk("rst_wr_addr", bus.wr_addr_o, 0);
    chk("rst_wr_data", bus.wr_data_o, 0);
    chk("rst_rdata0", bus.lcl_rdata_o, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write burst
    cs_begin();
    spi_bits(8'h03, 8, rx);
    spi_bits(8'hA5, 8, rx);
    spi_bits(8'h5A, 8, rx);
    cs_end();
    chk("wr_stb_count", stb_log.size(), 2);
    if (stb_log.size() == 2) begin
      chk("wr_stb_0", stb_log[0], 12'h3A5);
      chk("wr_stb_1", stb_log[1], 12'h45A);
    end
    peek(3, v); chk("wr_reg3", v, 8'hA5);
    peek(4, v); chk("wr_reg4", v, 8'h5A);
    stb_log.delete();

    // Read burst
    @(negedge clk);
    cs_begin();
    chk("rd_oe_selected", bus.miso_oe_o, 1);
    spi_bits(8'h83, 8, rx);
    spi_bits(8'h00, 8, rx); chk("rd_byte0", rx, 8'hA5);
    spi_bits(8'h00, 8, rx); chk("rd_byte1", rx, 8'h5A);
    cs_end();
    chk("rd_oe_deselected", bus.miso_oe_o, 0);
    chk("rd_no_stb", stb_log.size(), 0);

    // Wrap-around
    cs_begin();
    spi_bits(8'h0F, 8, rx);
    spi_bits(8'h11, 8, rx);
    spi_bits(8'h22, 8, rx);
    cs_end();
    peek(15, v); chk("wrap_reg15", v, 8'h11);
    peek(0, v);  chk("wrap_reg0", v, 8'h22);
    chk("wrap_stb_count", stb_log.size(), 2);
    if (stb_log.size() == 2) chk("wrap_stb_1", stb_log[1], 12'h022);
    stb_log.delete();
    @(negedge clk);
    cs_begin();
    spi_bits(8'h8F, 8, rx);
    spi_bits(8'h00, 8, rx); chk("wrap_rd0", rx, 8'h11);
    spi_bits(8'h00, 8, rx); chk("wrap_rd1", rx, 8'h22);
    cs_end();

    // Abort mid-byte
    cs_begin();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'hFF, 5, rx);
    cs_end();
    peek(2, v); chk("abort_reg2", v, 8'h00);
    chk("abort_no_stb", stb_log.size(), 0);
    @(negedge clk);
    cs_begin();
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h77, 8, rx);
    cs_end();
    peek(2, v); chk("after_abort_reg2", v, 8'h77);
    chk("after_abort_stb", stb_log.size(), 1);
    stb_log.delete();

    // Local/SPI write collision
    @(negedge clk);
    cs_begin();
    spi_bits(8'h05, 8, rx);
    spi_byte_coll(8'hC3, 4'd5, 8'h33);
    cs_end();
    peek(5, v); chk("coll_same_idx", v, 8'hC3);
    @(negedge clk);
    cs_begin();
    spi_bits(8'h05, 8, rx);
    spi_byte_coll(8'hC3, 4'd6, 8'h33);
    cs_end();
    peek(6, v); chk("coll_other_idx6", v, 8'h33);
    peek(5, v); chk("coll_other_idx5", v, 8'hC3);
    chk("coll_stb_count", stb_log.size(), 2);
    stb_log.delete();

    // Reset during the 4th bit of a read data byte (reg4 = 0x5A, 4th bit is 1)
    @(negedge clk);
    cs_begin();
    spi_bits(8'h84, 8, rx);
    spi_bits(8'h00, 3, rx);
    chk("mid_rd_bits", rx, 8'h40);
    repeat (4) @(negedge clk);
    chk("mid_rd_miso", bus.miso_o, 1);
    bus.sck_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstmid_miso", bus.miso_o, 0);
    chk("rstmid_oe", bus.miso_oe_o, 0);
    for (int i = 0; i < 16; i++) begin
      peek(i, v);
      chk($sformatf("rstmid_reg%0d", i), v, 8'h00);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    bus.sck_i = 1'b0;
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h99, 8, rx);
    cs_end();
    peek(1, v); chk("post_rst_no_write", v, 8'h00);
    chk("post_rst_no_stb", stb_log.size(), 0);
    @(negedge clk);
    cs_begin();
    spi_bits(8'h80, 8, rx);
    spi_bits(8'h00, 8, rx); chk("post_rst_rd0", rx, 8'h00);
    cs_end();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
